// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR3 command-port arbiter.
// Command encodings match the DDR IP user interface.
package ddr_pkg;

  localparam int ADDR_W     = 29;
  localparam int ADDR_STEP  = 8;
  localparam int RD_CNT_W   = 5;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_WR = 1'b0,
    SRC_RD = 1'b1
  } gnt_src_e;

  // Round-robin pick when both requesters are eligible and neither is urgent.
  function automatic arb_state_e alternate_pick(input gnt_src_e last_gnt);
    return (last_gnt == SRC_RD) ? GNT_WR : GNT_RD;
  endfunction

endpackage

// File: rtl/ddr_rd_credit.sv
// Up/down counter of read commands whose data beat has not yet returned.
// full gates new reads; full_next lets the arbiter drop the grant on the filling read.
module ddr_rd_credit
  import ddr_pkg::*;
#(
  parameter int MAX_OUT = 16,
  parameter int CNT_W   = RD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             full_next
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign full      = (cnt_q == CNT_W'(MAX_OUT));
  assign full_next = (cnt_d == CNT_W'(MAX_OUT));

  // A return with nothing in flight, or a read issued while full, means upstream broke the protocol.
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && (cnt_q == '0)));
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && full));

endmodule

// File: rtl/ddr_cmd_arb.sv
// Arbitrates the single DDR3 command port between the capture write path and the readout path.
// Commands issue combinationally from the grant state; every grant change passes through IDLE.
module ddr_cmd_arb
  import ddr_pkg::*;
#(
  parameter int ADDR_W     = ddr_pkg::ADDR_W,
  parameter int MAX_BURST  = 30,
  parameter int MAX_RD_OUT = 16,
  parameter int ADDR_STEP  = ddr_pkg::ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic              wr_urgent,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  input  logic              ddr_cmd_rdy,
  input  logic              ddr_wr_data_rdy,
  input  logic              ddr_rd_data_valid,
  output logic [2:0]        ddr_cmd,
  output logic              ddr_cmd_en,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_wr_data_en,
  output logic              ddr_wr_data_end,
  output logic [4:0]        rd_outstanding,
  output logic              busy
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  gnt_src_e           last_gnt_q, last_gnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic wr_fire;
  logic rd_fire;
  logic leave;
  logic rd_ok;
  logic burst_last;
  logic rd_full;
  logic rd_full_next;

  ddr_rd_credit #(
    .MAX_OUT (MAX_RD_OUT),
    .CNT_W   (5)
  ) u_rd_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (rd_fire),
    .dec       (ddr_rd_data_valid),
    .cnt       (rd_outstanding),
    .full      (rd_full),
    .full_next (rd_full_next)
  );

  assign burst_last = (burst_cnt_q == BURST_W'(MAX_BURST - 1));
  assign rd_ok      = rd_req && !rd_full;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    wr_fire     = 1'b0;
    rd_fire     = 1'b0;
    leave       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (init_calib_complete) begin
          if (wr_req && wr_urgent) begin
            state_d = GNT_WR;
          end else if (wr_req && rd_ok) begin
            state_d = alternate_pick(last_gnt_q);
          end else if (wr_req) begin
            state_d = GNT_WR;
          end else if (rd_ok) begin
            state_d = GNT_RD;
          end
        end
      end
      GNT_WR: begin
        wr_fire = init_calib_complete && wr_req && ddr_cmd_rdy && ddr_wr_data_rdy;
        leave   = !init_calib_complete || !wr_req || (wr_fire && burst_last);
      end
      GNT_RD: begin
        rd_fire = init_calib_complete && rd_req && ddr_cmd_rdy && !rd_full;
        // Urgent writes preempt reads; a read firing this cycle still completes.
        leave   = !init_calib_complete || !rd_req || (rd_fire && burst_last) ||
                  rd_full_next || (wr_urgent && wr_req);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr_fire || rd_fire) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end

    if (leave) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
      last_gnt_d  = (state_q == GNT_WR) ? SRC_WR : SRC_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= SRC_RD;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Idle values: read opcode, zero address, all strobes low.
  always_comb begin
    ddr_cmd_en      = wr_fire || rd_fire;
    ddr_wr_data_en  = wr_fire;
    ddr_wr_data_end = wr_fire;
    wr_ack          = wr_fire;
    rd_ack          = rd_fire;
    ddr_cmd         = wr_fire ? CMD_WR : CMD_RD;
    ddr_addr        = '0;
    if (wr_fire) begin
      ddr_addr = wr_addr;
    end else if (rd_fire) begin
      ddr_addr = rd_addr;
    end
  end

  assign busy = (state_q != IDLE);

  a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
    ddr_cmd_en |-> ((64'(ddr_addr) % 64'(ADDR_STEP)) == 64'd0));

endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Bench for ddr_cmd_arb: IDLE arbitration vector table, multi-cycle corner sequences,
// and a randomized run against a grant-level reference model.
module tb_ddr_cmd_arb;

  localparam int AW = 29;
  localparam logic [AW-1:0] BASE = 29'h0100_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib, wr_req, wr_urgent, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ack, rd_ack;
  logic          cmd_rdy, wdata_rdy, rd_valid;
  logic [2:0]    ddr_cmd;
  logic          ddr_cmd_en, wd_en, wd_end, busy;
  logic [AW-1:0] ddr_addr;
  logic [4:0]    rd_out;

  int total = 0;
  int bad   = 0;

  ddr_cmd_arb #(.ADDR_W(AW), .MAX_BURST(30), .MAX_RD_OUT(16), .ADDR_STEP(8)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .wr_req(wr_req), .wr_urgent(wr_urgent), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .ddr_cmd_rdy(cmd_rdy), .ddr_wr_data_rdy(wdata_rdy), .ddr_rd_data_valid(rd_valid),
    .ddr_cmd(ddr_cmd), .ddr_cmd_en(ddr_cmd_en), .ddr_addr(ddr_addr),
    .ddr_wr_data_en(wd_en), .ddr_wr_data_end(wd_end),
    .rd_outstanding(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic en, input logic wa, input logic ra,
                                       input logic de, input logic dn, input logic bz,
                                       input logic [4:0] ro, input logic [2:0] cm,
                                       input logic [AW-1:0] ad);
    return {21'd0, en, wa, ra, de, dn, bz, ro, cm, ad};
  endfunction

  function automatic int ev_now();
    if (!ddr_cmd_en) return 0;
    return (ddr_cmd == 3'd0) ? 1 : 2;
  endfunction

  task automatic idle_inputs();
    calib = 1'b1; wr_req = 1'b0; wr_urgent = 1'b0; rd_req = 1'b0;
    cmd_rdy = 1'b1; wdata_rdy = 1'b1; rd_valid = 1'b0;
    wr_addr = '0; rd_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic calib;
    logic wr;
    logic urg;
    logic rd;
    int   exp;   // 0 no grant, 1 write grant, 2 read grant
  } idle_vec_t;

  idle_vec_t vt[8];

  // Reference model state, expressed as grant ownership and counts.
  int m_owner, m_ncmd, m_last, m_infl;

  initial begin
    int n, hit, first_cyc, first_kind, cnt, nmis, first_ack_seen, run, started;
    int ev[$];
    logic [AW-1:0] first_addr;
    logic prev_rd_ack;
    logic [31:0] r;

    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 2};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 2};
    vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};

    // Reset dominates even with requests present.
    idle_inputs();
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = BASE; rd_addr = BASE;
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", pack(ddr_cmd_en, wr_ack, rd_ack, wd_en, wd_end, busy, rd_out, ddr_cmd, ddr_addr),
          pack(0, 0, 0, 0, 0, 0, 5'd0, 3'd1, '0));

    // IDLE arbitration table
    foreach (vt[i]) begin
      do_reset();
      calib = vt[i].calib; wr_req = vt[i].wr; wr_urgent = vt[i].urg; rd_req = vt[i].rd;
      cmd_rdy = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_idle_en", i), {ddr_cmd_en, busy}, 2'b00);
      next_drive();
      cmd_rdy = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), {wr_ack, rd_ack, busy},
            {vt[i].exp == 1, vt[i].exp == 2, vt[i].exp != 0});
    end

    // Uncalibrated: nothing issues; calibration then grants write first.
    do_reset();
    calib = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ddr_cmd_en) cnt++;
      next_drive();
    end
    check("nocalib_cmd_en_count", cnt, 0);
    calib = 1'b1;
    first_cyc = -1; first_kind = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ddr_cmd_en && first_cyc < 0) begin first_cyc = c; first_kind = ev_now(); end
      next_drive();
    end
    check("calib_first_issue_cycle", first_cyc, 1);
    check("calib_first_issue_kind", first_kind, 1);

    // Read credit limit: 16 reads then stall, one return frees exactly one more.
    do_reset();
    rd_req = 1'b1; n = 0;
    for (int c = 0; c < 60; c++) begin
      rd_addr = BASE + AW'(8 * n);
      @(negedge clk);
      if (rd_ack) n++;
      next_drive();
    end
    check("rd_limit_count", n, 16);
    check("rd_limit_outstanding", rd_out, 16);
    check("rd_limit_idle", busy, 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      rd_valid = (c == 0);
      rd_addr = BASE + AW'(8 * n);
      @(negedge clk);
      if (rd_ack) begin cnt++; n++; end
      next_drive();
    end
    rd_valid = 1'b0;
    check("rd_credit_return_count", cnt, 1);
    check("rd_credit_outstanding", rd_out, 16);

    // Both requesting, reads returned one cycle later: 30/30 alternation with one gap.
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1; prev_rd_ack = 1'b0;
    ev.delete();
    for (int c = 0; c < 200; c++) begin
      rd_valid = prev_rd_ack;
      @(negedge clk);
      prev_rd_ack = rd_ack;
      ev.push_back(ev_now());
      next_drive();
    end
    rd_valid = 1'b0;
    nmis = 0; first_cyc = -1;
    foreach (ev[i]) begin
      int e;
      if (i == 0) e = 0;
      else if (((i - 1) % 31) == 30) e = 0;
      else e = ((((i - 1) / 31) % 2) == 0) ? 1 : 2;
      if (ev[i] != e) begin
        nmis++;
        if (first_cyc < 0) first_cyc = i;
      end
    end
    check("alternate_pattern_mismatches", nmis, 0);
    check("alternate_first_bad_cycle", first_cyc, -1);

    // Urgent write preempts a read burst after its 6th command.
    do_reset();
    rd_req = 1'b1; n = 0; cnt = -1; first_cyc = -1;
    for (int c = 0; c < 15; c++) begin
      if (n == 5) begin wr_req = 1'b1; wr_urgent = 1'b1; end
      rd_addr = BASE + AW'(8 * n);
      @(negedge clk);
      if (rd_ack) begin n++; cnt = c; end
      if (wr_ack && first_cyc < 0) first_cyc = c;
      next_drive();
    end
    check("urgent_rd_count", n, 6);
    check("urgent_wr_latency", first_cyc - cnt, 2);

    // Write data not ready: no strobes until it returns; cmd/data strobes coincide.
    do_reset();
    wr_req = 1'b1; wdata_rdy = 1'b0;
    cnt = 0; nmis = 0; n = 0;
    for (int c = 0; c < 12; c++) begin
      wdata_rdy = (c >= 8);
      wr_addr = BASE + AW'(8 * n);
      @(negedge clk);
      if (c < 8 && (ddr_cmd_en || wr_ack)) cnt++;
      if (c >= 8 && wr_ack) n++;
      if (!(ddr_cmd_en == wd_en && wd_en == wd_end && wd_en == wr_ack)) nmis++;
      next_drive();
    end
    check("wdata_stall_strobes", cnt, 0);
    check("wdata_resume_acks", n, 4);
    check("wdata_strobe_coincidence", nmis, 0);

    // Reset on the 12th write: outputs drop at once, command is re-presented afterwards.
    do_reset();
    wr_req = 1'b1; n = 0; hit = 0;
    for (int c = 0; c < 40 && hit == 0; c++) begin
      wr_addr = BASE + AW'(8 * n);
      @(negedge clk);
      if (wr_ack) begin
        n++;
        if (n == 12) begin
          hit = 1;
          rst = 1'b1;
          #1;
          check("rst_mid_burst_outputs", pack(ddr_cmd_en, wr_ack, rd_ack, wd_en, wd_end, busy, rd_out, ddr_cmd, ddr_addr),
                pack(0, 0, 0, 0, 0, 0, 5'd0, 3'd1, '0));
          n--;
        end
      end
      if (hit == 0) next_drive();
    end
    check("rst_reached_cmd12", hit, 1);
    next_drive();
    rst = 1'b0;
    first_ack_seen = 0; first_addr = '0; run = 0; started = 0;
    for (int c = 0; c < 40; c++) begin
      wr_addr = BASE + AW'(8 * n);
      @(negedge clk);
      if (wr_ack) begin
        if (!first_ack_seen) begin first_ack_seen = 1; first_addr = ddr_addr; end
        n++;
        if (started != 2) begin started = 1; run++; end
      end else if (started == 1) begin
        started = 2;
      end
      next_drive();
    end
    check("rst_represent_addr", first_addr, BASE + AW'(8 * 11));
    check("rst_fresh_burst_len", run, 30);

    // Randomized run against the grant-level model.
    do_reset();
    m_owner = 0; m_ncmd = 0; m_last = 2; m_infl = 0;
    nmis = 0;
    for (int c = 0; c < 3000; c++) begin
      logic ew, er, fired, lv;
      int infl_n;
      calib     = ($urandom_range(0, 31) != 0);
      wr_req    = ($urandom_range(0, 3) != 0);
      rd_req    = ($urandom_range(0, 3) != 0);
      wr_urgent = ($urandom_range(0, 15) == 0);
      cmd_rdy   = ($urandom_range(0, 7) != 0);
      wdata_rdy = ($urandom_range(0, 7) != 0);
      rd_valid  = (m_infl > 0) && ($urandom_range(0, 2) != 0);
      r = $urandom(); wr_addr = {r[25:0], 3'b000};
      r = $urandom(); rd_addr = {r[25:0], 3'b000};
      @(negedge clk);
      ew = (m_owner == 1) && calib && wr_req && cmd_rdy && wdata_rdy;
      er = (m_owner == 2) && calib && rd_req && cmd_rdy && (m_infl < 16);
      check($sformatf("rand_cycle%0d", c),
            pack(ddr_cmd_en, wr_ack, rd_ack, wd_en, wd_end, busy, rd_out, ddr_cmd, ddr_addr),
            pack(ew | er, ew, er, ew, ew, m_owner != 0, 5'(m_infl), ew ? 3'd0 : 3'd1,
                 ew ? wr_addr : (er ? rd_addr : '0)));
      infl_n = m_infl + (er ? 1 : 0) - (rd_valid ? 1 : 0);
      fired = ew | er;
      if (m_owner == 0) begin
        if (calib) begin
          if (wr_req && wr_urgent) m_owner = 1;
          else if (wr_req && rd_req && m_infl < 16) m_owner = (m_last == 2) ? 1 : 2;
          else if (wr_req) m_owner = 1;
          else if (rd_req && m_infl < 16) m_owner = 2;
        end
      end else begin
        lv = !calib || (m_owner == 1 ? !wr_req : !rd_req) || (fired && (m_ncmd + 1 == 30)) ||
             (m_owner == 2 && (infl_n == 16 || (wr_urgent && wr_req)));
        if (lv) begin
          m_last = m_owner; m_owner = 0; m_ncmd = 0;
        end else if (fired) begin
          m_ncmd++;
        end
      end
      m_infl = infl_n;
      next_drive();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
